// File: rtl/seg7_msg_scan.sv
// Multiplexed 7-segment message display: character buffer, glyph decode, blink, blanking, frame strobe.
// Optional window scrolling is compiled in with `define SEG7_SCROLL_EN.
module seg7_msg_scan #(
  parameter int NUM_DIGITS    = 8,
  parameter int SCAN_BITS     = 10,
  parameter int MSG_LEN       = 16,
  parameter int BLINK_BITS    = 24,
  parameter int SCROLL_FRAMES = 16,
  parameter bit ACTIVE_LOW    = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       blink,
  input  logic                       scroll_on,
  input  logic                       wr_en,
  input  logic [$clog2(MSG_LEN)-1:0] wr_addr,
  input  logic [4:0]                 wr_char,
  output logic [NUM_DIGITS-1:0]      digit_anode_w,
  output logic [7:0]                 segment_w,
  output logic                       frame_tick
);

  localparam int ADDR_W = $clog2(MSG_LEN);
  localparam int DIG_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [4:0] CHAR_BLANK = 5'h10;
  localparam logic [7:0] SEG_OFF    = 8'hFF;

  // Glyph table is kept active-low; output polarity is applied at the pins.
  function automatic logic [7:0] glyph(input logic [4:0] code);
    case (code)
      5'h00: glyph = 8'hC0;  5'h01: glyph = 8'hF9;  5'h02: glyph = 8'hA4;  5'h03: glyph = 8'hB0;
      5'h04: glyph = 8'h99;  5'h05: glyph = 8'h92;  5'h06: glyph = 8'h82;  5'h07: glyph = 8'hF8;
      5'h08: glyph = 8'h80;  5'h09: glyph = 8'h90;  5'h0A: glyph = 8'h88;  5'h0B: glyph = 8'h83;
      5'h0C: glyph = 8'hC6;  5'h0D: glyph = 8'hA1;  5'h0E: glyph = 8'h86;  5'h0F: glyph = 8'h8E;
      5'h11: glyph = 8'h92;  5'h12: glyph = 8'hC1;  5'h13: glyph = 8'hC7;  5'h14: glyph = 8'h8C;
      5'h15: glyph = 8'h89;  5'h16: glyph = 8'hBF;  5'h17: glyph = 8'hE3;
      default: glyph = SEG_OFF;
    endcase
  endfunction

  logic [SCAN_BITS-1:0]  sub_q, sub_d;
  logic [DIG_W-1:0]      digit_q, digit_d;
  logic [BLINK_BITS-1:0] blink_q;
  logic [4:0]            mem_q [MSG_LEN];
  logic [ADDR_W-1:0]     base;
  logic                  wrap;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    wrap    = (sub_q == '1) && (digit_q == DIG_W'(NUM_DIGITS - 1));
    sub_d   = sub_q + SCAN_BITS'(1);
    digit_d = digit_q;
    if (sub_q == '1) digit_d = wrap ? '0 : digit_q + DIG_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      sub_q   <= '0;
      digit_q <= '0;
      blink_q <= '0;
    end else begin
      sub_q   <= sub_d;
      digit_q <= digit_d;
      blink_q <= blink_q + BLINK_BITS'(1);
    end
  end

  // NOTE: the buffer must come up blank, so it is reset and therefore built from flops, not RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MSG_LEN; i++) mem_q[i] <= CHAR_BLANK;
    end else if (wr_en) begin
      mem_q[wr_addr] <= wr_char;
    end
  end

`ifdef SEG7_SCROLL_EN
  localparam int FR_W = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;
  logic [FR_W-1:0]   frame_q, frame_d;
  logic [ADDR_W-1:0] base_q, base_d;

  always_comb begin
    frame_d = frame_q;
    base_d  = base_q;
    if (scroll_on && wrap) begin
      if (frame_q == FR_W'(SCROLL_FRAMES - 1)) begin
        frame_d = '0;
        base_d  = base_q + ADDR_W'(1);
      end else begin
        frame_d = frame_q + FR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_q <= '0;
      base_q  <= '0;
    end else begin
      frame_q <= frame_d;
      base_q  <= base_d;
    end
  end

  assign base = base_q;
`else
  logic unused_scroll;
  assign unused_scroll = scroll_on ^ (SCROLL_FRAMES == 0);
  assign base = '0;
`endif

  logic [ADDR_W-1:0]     rd_addr;
  logic [NUM_DIGITS-1:0] anode_on, anode_d, anode_q;
  logic [7:0]            seg_n, seg_d, seg_q;
  logic                  tick_q;

  // Same-cycle write to the displayed entry reads the old value from mem_q.
  always_comb begin
    rd_addr  = base + ADDR_W'(digit_q);
    anode_on = '0;
    for (int i = 0; i < NUM_DIGITS; i++) anode_on[i] = en && (digit_q == DIG_W'(i));
    seg_n = glyph(mem_q[rd_addr]);
    if (!en || (blink && blink_q[BLINK_BITS-1])) seg_n = SEG_OFF;
    anode_d = ACTIVE_LOW ? ~anode_on : anode_on;
    seg_d   = ACTIVE_LOW ? seg_n : ~seg_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      anode_q <= {NUM_DIGITS{ACTIVE_LOW}};
      seg_q   <= {8{ACTIVE_LOW}};
      tick_q  <= 1'b0;
    end else begin
      anode_q <= anode_d;
      seg_q   <= seg_d;
      tick_q  <= wrap;
    end
  end

  assign digit_anode_w = anode_q;
  assign segment_w     = seg_q;
  assign frame_tick    = tick_q;

endmodule

// File: tb/tb_seg7_msg_scan.sv
// Scoreboard bench for seg7_msg_scan: a cycle-count based reference model predicts the pins,
// a separate monitor compares them one cycle after each stimulus edge.
module tb_seg7_msg_scan;
  localparam int ND = 4;
  localparam int SB = 2;
  localparam int ML = 8;
  localparam int BB = 3;
  localparam int SF = 2;
  localparam int FRAME = ND * (1 << SB);

  logic       clk = 1'b0;
  logic       rst, en, blink, scroll_on, wr_en;
  logic [2:0] wr_addr;
  logic [4:0] wr_char;
  logic [3:0] digit_anode_w;
  logic [7:0] segment_w;
  logic       frame_tick;

  seg7_msg_scan #(
    .NUM_DIGITS(ND), .SCAN_BITS(SB), .MSG_LEN(ML), .BLINK_BITS(BB),
    .SCROLL_FRAMES(SF), .ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .blink(blink), .scroll_on(scroll_on),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_char(wr_char),
    .digit_anode_w(digit_anode_w), .segment_w(segment_w), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] anode;
    logic [7:0] seg;
    logic       tick;
  } exp_t;

  localparam logic [7:0] HEX_GLYPH [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  exp_t       exp_q [$];
  exp_t       mx;
  logic [7:0] glyph_tab [32];
  logic [4:0] mbuf [ML];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         c        = 0;
  int         base     = 0;
  int         frames   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
    end
  endtask

  // Drive one cycle of inputs and push what the pins must show after the next edge.
  task automatic step(input logic r, input logic e, input logic b, input logic s,
                      input logic w, input logic [2:0] a, input logic [4:0] ch);
    exp_t x;
    int   d;
    @(negedge clk);
    rst = r; en = e; blink = b; scroll_on = s; wr_en = w; wr_addr = a; wr_char = ch;
    if (r) begin
      x = '{anode: 4'hF, seg: 8'hFF, tick: 1'b0};
      c = 0; base = 0; frames = 0;
      foreach (mbuf[k]) mbuf[k] = 5'h10;
    end else begin
      d       = (c / (1 << SB)) % ND;
      x.anode = e ? ~(4'b0001 << d) : 4'hF;
      x.seg   = (!e || (b && ((c % (1 << BB)) >= (1 << (BB - 1))))) ? 8'hFF
              : glyph_tab[mbuf[(base + d) % ML]];
      x.tick  = ((c % FRAME) == FRAME - 1);
`ifdef SEG7_SCROLL_EN
      if (s && x.tick) begin
        frames++;
        if (frames == SF) begin
          frames = 0;
          base   = (base + 1) % ML;
        end
      end
`endif
      if (w) mbuf[a] = ch;
      c++;
    end
    exp_q.push_back(x);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        mx = exp_q.pop_front();
        check("digit_anode_w", 32'(digit_anode_w), 32'(mx.anode));
        check("segment_w", 32'(segment_w), 32'(mx.seg));
        check("frame_tick", 32'(frame_tick), 32'(mx.tick));
      end
    end
  end

  initial begin
    foreach (glyph_tab[k]) glyph_tab[k] = 8'hFF;
    for (int k = 0; k < 16; k++) glyph_tab[k] = HEX_GLYPH[k];
    glyph_tab[5'h11] = 8'h92; glyph_tab[5'h12] = 8'hC1; glyph_tab[5'h13] = 8'hC7;
    glyph_tab[5'h14] = 8'h8C; glyph_tab[5'h15] = 8'h89; glyph_tab[5'h16] = 8'hBF;
    glyph_tab[5'h17] = 8'hE3;
    foreach (mbuf[k]) mbuf[k] = 5'h10;
    rst = 1'b1; en = 1'b0; blink = 1'b0; scroll_on = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_char = '0;

    repeat (2) step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 3'd0, 5'h11);
    step(0, 0, 0, 0, 1, 3'd1, 5'h12);
    step(0, 0, 0, 0, 1, 3'd2, 5'h0C);
    step(0, 0, 0, 0, 1, 3'd3, 5'h0C);
    repeat (48) step(0, 1, 0, 0, 0, 0, 0);
    repeat (32) step(0, 1, 1, 0, 0, 0, 0);
    repeat (8)  step(0, 1, 0, 0, 0, 0, 0);
    repeat (3)  step(0, 0, 0, 0, 0, 0, 0);
    repeat (10) step(0, 1, 0, 0, 0, 0, 0);

    while ((c % FRAME) != 9) step(0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 1, 3'd2, 5'h15);
    repeat (20) step(0, 1, 0, 0, 0, 0, 0);

    repeat (600) step(0, $urandom_range(0, 7) != 0, $urandom_range(0, 3) == 0,
                      $urandom_range(0, 1) == 1, $urandom_range(0, 5) == 0,
                      3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));

    repeat (5) step(0, 1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 1, 3'd4, 5'h03);
    repeat (20) step(0, 1, 0, 0, 0, 0, 0);

    for (int k = 0; k < ML; k++) step(0, 1, 0, 0, 1, 3'(k), 5'(k));
    repeat (300) step(0, 1, 0, 1, 0, 0, 0);

    @(negedge clk);
    @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
